// File: rtl/skinny_stream_io.sv
// Serial load/unload front end for a SKINNY-128 core: gathers plaintext and tweakey beats into
// full-width registers, pulses the core, captures ciphertext and streams it back out MSB-first.
module skinny_stream_io #(
    parameter int DW     = 8,
    parameter int TK_NUM = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DW-1:0]           in_pt_i,
    input  logic [DW*TK_NUM-1:0]    in_tk_i,
    output logic                    core_start_o,
    output logic [127:0]            core_pt_o,
    output logic [128*TK_NUM-1:0]   core_tk_o,
    input  logic                    core_done_i,
    input  logic [127:0]            core_ct_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DW-1:0]           out_ct_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int BEATS = 128 / DW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = DW * TK_NUM;
    localparam int KW    = 128 * TK_NUM;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        UNLOAD = 2'd3
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [127:0]    pt_q;
    logic [KW-1:0]   tk_q;
    logic [127:0]    ct_q;
    logic            core_start_q;
    logic            done_q;
    logic            cnt_last;

    // One counter serves both directions: beats loaded in LOAD, beats emitted in UNLOAD.
    assign cnt_last = (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pt_q         <= '0;
            tk_q         <= '0;
            ct_q         <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt_q == CW'(b)) begin
                                pt_q[127-b*DW -: DW] <= in_pt_i;
                                tk_q[KW-1-b*TW -: TW] <= in_tk_i;
                            end
                        end
                        if (cnt_last) begin
                            state_q      <= RUN;
                            core_start_q <= 1'b1;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // core_done coinciding with the core_start pulse is a legal fast core.
                    if (core_done_i) begin
                        ct_q    <= core_ct_i;
                        cnt_q   <= '0;
                        state_q <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (out_ready_i) begin
                        if (cnt_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_ct_o = '0;
        if (state_q == UNLOAD) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CW'(b)) begin
                    out_ct_o = ct_q[127-b*DW -: DW];
                end
            end
        end
    end

    assign in_ready_o   = (state_q == LOAD);
    assign out_valid_o  = (state_q == UNLOAD);
    assign out_last_o   = (state_q == UNLOAD) && cnt_last;
    assign busy_o       = (state_q != IDLE);
    assign core_start_o = core_start_q;
    assign done_o       = done_q;
    assign core_pt_o    = pt_q;
    assign core_tk_o    = tk_q;

endmodule
